// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        REL_SYS = 2'd1,
        REL_PMA = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;
    localparam logic [1:0] CAUSE_WDOG = 2'b11;

    // Active-low stage resets for a state, packed as {pcs, pma, sys}.
    function automatic logic [2:0] stage_rst_n(input state_t s);
        logic [2:0] v;
        v = 3'b000;
        case (s)
            ASSERT:  v = 3'b000;
            REL_SYS: v = 3'b001;
            REL_PMA: v = 3'b011;
            RUN:     v = 3'b111;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear/enable and a terminal-count compare output.
// Latency: count updates one clock after clr/en; o_at_term is combinational on the count.
// Backpressure: none; clear has priority over enable.
// Ports: i_clk/i_rst_n clock and sync active-low reset, i_clr clear, i_en count enable,
//        i_term terminal value, o_cnt current count, o_at_term count equals i_term.
module rst_seq_timer
    import rst_seq_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all block resets, then releases sys -> pma -> pcs; records the cause.
// Latency: sys release HOLD_CYCLES clocks after lock is stable, each later stage STAGE_GAP after.
// Backpressure: none; abort events (lock loss > watchdog > SW) reassert all resets next edge.
// Ports: sys_clk_25m/reset_n clock and sync active-low board reset; pll_locked_i, sw_rst_req_i,
//        wdog_en_i, wdog_kick_i, cause_clr_i control inputs; *_rst_n_o staged resets,
//        rst_done_o sequence complete, rst_cause_o last cause, wdog_fired_o sticky watchdog flag.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDOG_CYCLES = 65536,
    parameter int CNT_W       = 17
) (
    input  logic       sys_clk_25m,
    input  logic       reset_n,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    input  logic       wdog_en_i,
    input  logic       wdog_kick_i,
    input  logic       cause_clr_i,
    output logic       sys_rst_n_o,
    output logic       pma_rst_n_o,
    output logic       pcs_rst_n_o,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o,
    output logic       wdog_fired_o
);

    localparam logic [CNT_W-1:0] L_HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_GAP_TERM  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] L_WDOG_TERM = CNT_W'(WDOG_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_stage_rst_n;
    logic             r_done;
    logic [1:0]       r_cause;
    logic             r_wdog_fired;

    logic [CNT_W-1:0] w_stg_cnt;
    logic [CNT_W-1:0] w_stg_term;
    logic             w_stg_at_term;
    logic             w_stg_clr;
    logic             w_stg_en;
    logic [CNT_W-1:0] w_wd_cnt_unused;
    logic             w_wd_at_term;
    logic             w_wd_clr;

    logic             w_ab_lock;
    logic             w_ab_wdog;
    logic             w_ab_sw;
    logic             w_abort;
    logic [1:0]       w_ab_cause;

    // One counter serves both the ASSERT hold time and the inter-stage gaps;
    // it is always cleared on a state change so each phase starts from zero.
    assign w_stg_term = (r_state == ASSERT) ? L_HOLD_TERM : L_GAP_TERM;

    rst_seq_timer #(.CNT_W(CNT_W)) u_stg_timer (
        .i_clk     (sys_clk_25m),
        .i_rst_n   (reset_n),
        .i_clr     (w_stg_clr),
        .i_en      (w_stg_en),
        .i_term    (w_stg_term),
        .o_cnt     (w_stg_cnt),
        .o_at_term (w_stg_at_term)
    );

    // Watchdog only accumulates in RUN, enabled, with no kick; a kick on the
    // terminal clock suppresses the abort because w_ab_wdog requires no kick.
    assign w_wd_clr = (r_state != RUN) || !wdog_en_i || wdog_kick_i || w_abort;

    rst_seq_timer #(.CNT_W(CNT_W)) u_wd_timer (
        .i_clk     (sys_clk_25m),
        .i_rst_n   (reset_n),
        .i_clr     (w_wd_clr),
        .i_en      (1'b1),
        .i_term    (L_WDOG_TERM),
        .o_cnt     (w_wd_cnt_unused),
        .o_at_term (w_wd_at_term)
    );

    always_comb begin
        w_ab_lock   = (r_state != ASSERT) && !pll_locked_i;
        w_ab_wdog   = (r_state == RUN) && wdog_en_i && !wdog_kick_i && w_wd_at_term;
        w_ab_sw     = (r_state != ASSERT) && sw_rst_req_i;
        w_abort     = w_ab_lock || w_ab_wdog || w_ab_sw;
        w_ab_cause  = w_ab_lock ? CAUSE_LOCK : (w_ab_wdog ? CAUSE_WDOG : CAUSE_SW);

        w_state_nxt = r_state;
        w_stg_clr   = 1'b0;
        w_stg_en    = 1'b0;

        case (r_state)
            ASSERT: begin
                if (w_stg_at_term && pll_locked_i) begin
                    w_state_nxt = REL_SYS;
                    w_stg_clr   = 1'b1;
                end else if (pll_locked_i && !sw_rst_req_i) begin
                    w_stg_en    = 1'b1;
                end else begin
                    w_stg_clr   = 1'b1;
                end
            end
            REL_SYS, REL_PMA: begin
                if (w_abort) begin
                    w_state_nxt = ASSERT;
                    w_stg_clr   = 1'b1;
                end else if (w_stg_at_term) begin
                    w_state_nxt = (r_state == REL_SYS) ? REL_PMA : RUN;
                    w_stg_clr   = 1'b1;
                end else begin
                    w_stg_en    = 1'b1;
                end
            end
            RUN: begin
                w_stg_clr = 1'b1;
                if (w_abort) begin
                    w_state_nxt = ASSERT;
                end
            end
            default: begin
                w_state_nxt = ASSERT;
                w_stg_clr   = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge sys_clk_25m) begin
        if (!reset_n) begin
            r_state       <= ASSERT;
            r_stage_rst_n <= 3'b000;
            r_done        <= 1'b0;
            r_cause       <= CAUSE_POR;
            r_wdog_fired  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage_rst_n <= stage_rst_n(w_state_nxt);
            r_done        <= (w_state_nxt == RUN);

            // Inside ASSERT a repeated event only re-labels the cause once the
            // hold count had made progress; the initial abort edge leaves cnt at 0.
            if (w_abort) begin
                r_cause <= w_ab_cause;
            end else if ((r_state == ASSERT) && (w_stg_cnt != '0)) begin
                if (!pll_locked_i) begin
                    r_cause <= CAUSE_LOCK;
                end else if (sw_rst_req_i) begin
                    r_cause <= CAUSE_SW;
                end
            end

            if (w_abort && (w_ab_cause == CAUSE_WDOG)) begin
                r_wdog_fired <= 1'b1;
            end else if (cause_clr_i) begin
                r_wdog_fired <= 1'b0;
            end
        end
    end

    assign sys_rst_n_o  = r_stage_rst_n[0];
    assign pma_rst_n_o  = r_stage_rst_n[1];
    assign pcs_rst_n_o  = r_stage_rst_n[2];
    assign rst_done_o   = r_done;
    assign rst_cause_o  = r_cause;
    assign wdog_fired_o = r_wdog_fired;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int WDOG = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked_i;
    logic       sw_rst_req_i;
    logic       wdog_en_i;
    logic       wdog_kick_i;
    logic       cause_clr_i;
    logic       sys_rst_n_o;
    logic       pma_rst_n_o;
    logic       pcs_rst_n_o;
    logic       rst_done_o;
    logic [1:0] rst_cause_o;
    logic       wdog_fired_o;

    always #20 clk = ~clk;

    rst_seq_ctrl #(
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .WDOG_CYCLES (WDOG),
        .CNT_W       (17)
    ) dut (
        .sys_clk_25m  (clk),
        .reset_n      (reset_n),
        .pll_locked_i (pll_locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .wdog_en_i    (wdog_en_i),
        .wdog_kick_i  (wdog_kick_i),
        .cause_clr_i  (cause_clr_i),
        .sys_rst_n_o  (sys_rst_n_o),
        .pma_rst_n_o  (pma_rst_n_o),
        .pcs_rst_n_o  (pcs_rst_n_o),
        .rst_done_o   (rst_done_o),
        .rst_cause_o  (rst_cause_o),
        .wdog_fired_o (wdog_fired_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: m_hold = consecutive good clocks in the hold phase,
    // m_since = clocks since sys was released (-1 while held), m_idle = unkicked RUN clocks.
    int         m_hold  = 0;
    int         m_since = -1;
    int         m_idle  = 0;
    logic [1:0] m_cause = 2'b00;
    logic       m_fired = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step(input logic r, input logic l, input logic s,
                              input logic e, input logic k, input logic c);
        logic in_run;
        logic wd;
        in_run = 1'b0;
        wd     = 1'b0;
        if (!r) begin
            m_hold  = 0;
            m_since = -1;
            m_idle  = 0;
            m_cause = 2'b00;
            m_fired = 1'b0;
        end else begin
            if (m_since >= 0) begin
                in_run = (m_since >= 2 * GAP);
                wd     = in_run && e && !k && (m_idle == WDOG - 1);
                if (!l || wd || s) begin
                    m_cause = !l ? 2'b10 : (wd ? 2'b11 : 2'b01);
                    m_since = -1;
                    m_hold  = 0;
                    m_idle  = 0;
                end else begin
                    m_idle  = (in_run && e && !k) ? m_idle + 1 : 0;
                    m_since = m_since + 1;
                end
            end else begin
                if (m_hold > 0 && !l)     m_cause = 2'b10;
                else if (m_hold > 0 && s) m_cause = 2'b01;
                if (l && m_hold == HOLD - 1) begin
                    m_since = 0;
                    m_hold  = 0;
                end else if (l && !s) begin
                    m_hold = m_hold + 1;
                end else begin
                    m_hold = 0;
                end
            end
            if (wd && l)  m_fired = 1'b1;
            else if (c)   m_fired = 1'b0;
        end
    endtask

    // One clock: drive, advance model on the edge, then compare just after the edge.
    task automatic cyc(input string tag, input logic r, input logic l, input logic s,
                       input logic e, input logic k, input logic c);
        logic [3:0] exp_st;
        reset_n      = r;
        pll_locked_i = l;
        sw_rst_req_i = s;
        wdog_en_i    = e;
        wdog_kick_i  = k;
        cause_clr_i  = c;
        @(posedge clk);
        model_step(r, l, s, e, k, c);
        #1;
        if (m_since < 0)              exp_st = 4'b0000;
        else if (m_since >= 2 * GAP)  exp_st = 4'b1111;
        else if (m_since >= GAP)      exp_st = 4'b1100;
        else                          exp_st = 4'b1000;
        chk($sformatf("%s.stages", tag),
            {4'b0, sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o}, {4'b0, exp_st});
        chk($sformatf("%s.cause", tag), {6'b0, rst_cause_o}, {6'b0, m_cause});
        chk($sformatf("%s.fired", tag), {7'b0, wdog_fired_o}, {7'b0, m_fired});
    endtask

    initial begin
        logic rr, rl, rs, re, rk, rc;

        // Reset values
        repeat (3) cyc("por", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_vals", {sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o,
                           rst_cause_o, wdog_fired_o, 1'b0}, 8'h00);

        // 1: clean release with lock stable
        for (int c = 1; c <= 34; c++) begin
            cyc("t1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t1_seq_c%0d", c),
                {4'b0, sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o},
                {4'b0, (c >= 16), (c >= 24), (c >= 32), (c >= 32)});
        end
        chk("t1_cause", {6'b0, rst_cause_o}, 8'h00);

        // 2: late lock, then lock loss in RUN
        repeat (2) cyc("t2rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc("t2nolock", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            cyc("t2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 15 || c == 16)
                chk($sformatf("t2_sys_c%0d", c), {7'b0, sys_rst_n_o}, {7'b0, (c >= 16)});
        end
        chk("t2_cause_before", {6'b0, rst_cause_o}, 8'h00);
        cyc("t2loss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_lockloss", {sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o,
                            rst_cause_o, 2'b00}, 8'b0000_1000);

        // 3: SW pulse in REL_PMA, then SW held in ASSERT
        repeat (2) cyc("t3rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (25) cyc("t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_in_pma", {6'b0, pma_rst_n_o, pcs_rst_n_o}, 8'h02);
        cyc("t3sw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_sw_abort", {sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o,
                            rst_cause_o, 2'b00}, 8'b0000_0100);
        repeat (5) cyc("t3hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            cyc("t3re", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 15 || c == 16)
                chk($sformatf("t3_sys_c%0d", c), {7'b0, sys_rst_n_o}, {7'b0, (c >= 16)});
        end
        chk("t3_cause", {6'b0, rst_cause_o}, 8'h01);

        // 4: watchdog fires 64 clocks after RUN entry; kick on terminal clock saves it
        repeat (2) cyc("t4rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 96; c++) begin
            cyc("t4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (c == 95) chk("t4_pre_fire", {7'b0, rst_done_o}, 8'h01);
        end
        chk("t4_fire", {5'b0, rst_done_o, rst_cause_o}, 8'h03);
        chk("t4_fired", {7'b0, wdog_fired_o}, 8'h01);
        for (int c = 1; c <= 97; c++) begin
            cyc("t4k", 1'b1, 1'b1, 1'b0, 1'b1, (c == 96), 1'b0);
            if (c == 96 || c == 97)
                chk($sformatf("t4_kick_c%0d", c), {7'b0, rst_done_o}, 8'h01);
        end

        // 5: lock loss + SW together; cause_clr coinciding with a watchdog fire
        repeat (2) cyc("t5rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (33) cyc("t5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("t5both", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_prio", {5'b0, rst_done_o, rst_cause_o}, 8'h02);
        for (int c = 1; c <= 96; c++)
            cyc("t5wd", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (c == 96));
        chk("t5_set_wins", {5'b0, wdog_fired_o, rst_cause_o}, 8'h07);
        cyc("t5clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_clear", {7'b0, wdog_fired_o}, 8'h00);

        // 6: board reset in REL_SYS
        cyc("t6sw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc("t6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_in_sys", {6'b0, sys_rst_n_o, pma_rst_n_o}, 8'h02);
        cyc("t6rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_reset_vals", {sys_rst_n_o, pma_rst_n_o, pcs_rst_n_o, rst_done_o,
                              rst_cause_o, wdog_fired_o, 1'b0}, 8'h00);

        // 7: randomized traffic against the model
        re = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) re = ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 999) != 0);
            rl = ($urandom_range(0, 299) != 0);
            rs = ($urandom_range(0, 399) == 0);
            rk = ($urandom_range(0, 99) == 0);
            rc = ($urandom_range(0, 29) == 0);
            cyc("rnd", rr, rl, rs, re, rk, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
